// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad, debounces a single pressed key and
// hands its code to a consumer over a valid/ready handshake.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   cols[2:0]  - column sense, active-high, asynchronous (bit2 = left column)
//   rows[3:0]  - one-hot row drive, active-high (bit3 = top row)
//   key_valid  - key_code holds a qualified key
//   key_ready  - consumer accepts key_code
//   key_code   - qualified key code
//   key_held   - a qualified key is currently held down
//   overflow   - one-cycle pulse when a qualified press is dropped
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cols,
  output logic [3:0] rows,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       overflow
);

  localparam int unsigned DwW = $clog2(SCAN_DIV);
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DwW-1:0] DwellLast = DwW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0] DebLast   = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e         state_q, state_d;
  logic [2:0]     sync1_q, cs_q;
  logic [3:0]     rows_q, rows_d;
  logic [DwW-1:0] dwell_q, dwell_d;
  logic [DbW-1:0] deb_q, deb_d;
  logic [2:0]     pat_q, pat_d;
  logic           key_valid_q, key_valid_d;
  logic [3:0]     key_code_q, key_code_d;
  logic           overflow_q, overflow_d;

  logic [3:0] rows_next;
  logic       cs_one_hot;
  logic [1:0] row_idx, col_idx;
  logic [3:0] enc;

  // Two-flop synchronizer; nothing downstream looks at raw cols.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      cs_q    <= 3'b000;
    end else begin
      sync1_q <= cols;
      cs_q    <= sync1_q;
    end
  end

  assign rows_next  = {rows_q[0], rows_q[3:1]};
  assign cs_one_hot = (cs_q == 3'b001) || (cs_q == 3'b010) || (cs_q == 3'b100);

  // Key encoding from the frozen row and the captured column pattern.
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    unique case (rows_q)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      4'b0001: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    unique case (pat_q)
      3'b100:  col_idx = 2'd0;
      3'b010:  col_idx = 2'd1;
      3'b001:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
    if (row_idx == 2'd3) begin
      unique case (col_idx)
        2'd0:    enc = 4'hA;
        2'd1:    enc = 4'h0;
        default: enc = 4'hB;
      endcase
    end else begin
      enc = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    pat_d       = pat_q;
    // An accepted key clears on the next edge unless a new load overrides it.
    key_valid_d = key_valid_q && !key_ready;
    key_code_d  = key_code_q;
    overflow_d  = 1'b0;

    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (cs_one_hot) begin
            pat_d   = cs_q;
            deb_d   = '0;
            state_d = StDebounce;
          end else begin
            rows_d = rows_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StDebounce: begin
        if (cs_q != pat_q) begin
          state_d = StScan;
          rows_d  = rows_next;
          dwell_d = '0;
          deb_d   = '0;
        end else if (deb_q == DebLast) begin
          deb_d   = '0;
          state_d = StPressed;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StPressed: begin
        state_d = StRelease;
        deb_d   = '0;
        if (!key_valid_q || key_ready) begin
          key_valid_d = 1'b1;
          key_code_d  = enc;
        end else begin
          overflow_d = 1'b1;
        end
      end
      StRelease: begin
        if (cs_q != 3'b000) begin
          deb_d = '0;
        end else if (deb_q == DebLast) begin
          state_d = StScan;
          rows_d  = rows_next;
          dwell_d = '0;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StScan;
      rows_q      <= 4'b1000;
      dwell_q     <= '0;
      deb_q       <= '0;
      pat_q       <= 3'b000;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'hF;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      pat_q       <= pat_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rows      = rows_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overflow  = overflow_q;
  assign key_held  = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model closes a switch between the
// driven row and a column; expected key codes go into a queue and a monitor
// pops them on every valid/ready handshake.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [2:0] cols;
  logic [3:0] rows;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic [3:0] key_code;
  logic       key_held;
  logic       overflow;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cols     (cols),
    .rows     (rows),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_code (key_code),
    .key_held (key_held),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad legend, row-major from the top-left key.
  logic [3:0] keymap [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                              4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

  int         n_cmp = 0;
  int         n_bad = 0;
  int         ovf_seen = 0;
  int         exp_ovf = 0;
  logic [3:0] exp_q[$];

  logic       key_down = 1'b0;
  int         key_r = 0;
  int         key_c = 0;
  logic       force_en = 1'b0;
  logic [2:0] force_cols = 3'b000;
  logic       rand_ready = 1'b0;
  logic       ready_fixed = 1'b0;

  // Switch matrix: the pressed key connects its row line to its column line.
  always_comb begin
    cols = 3'b000;
    if (force_en) cols = force_cols;
    else if (key_down && (rows == (4'b1000 >> key_r))) cols = 3'b100 >> key_c;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready, changed just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    key_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Monitor / scoreboard.
  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (overflow) ovf_seen++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_key: got %0h expected none", key_code);
        end else begin
          e = exp_q.pop_front();
          check("key_code", 32'(key_code), 32'(e));
        end
      end
    end
  end

  task automatic press(input int r, input int c, input int hold, input bit chk_held,
                       input bit rel);
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
    repeat (hold) @(negedge clk);
    if (chk_held) check("key_held_during_press", 32'(key_held), 32'd1);
    if (rel) key_down = 1'b0;
  endtask

  task automatic wait_rows(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rows == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Release reset on a falling edge, then verify the scan phase from the first edge.
  task automatic release_and_check_scan();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("scan_rows_%0d", k), 32'(rows), 32'(4'b1000 >> ((k / 4) % 4)));
    end
    check("idle_no_valid", 32'(key_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int vcnt;
    int chg;
    int hcnt;
    logic [3:0] prev;
    int r;
    int c;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'hF);
    check("rst_rows", 32'(rows), 32'b1000);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    release_and_check_scan();

    // Key '8' with ready high: one-cycle valid, rows frozen, then next row.
    ready_fixed = 1'b1;
    exp_q.push_back(keymap[7]);
    key_r = 2;
    key_c = 1;
    key_down = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (key_valid) vcnt++;
    end
    check("valid_one_cycle", 32'(vcnt), 32'd1);
    check("rows_frozen", 32'(rows), 32'b0010);
    check("held_8", 32'(key_held), 32'd1);
    key_down = 1'b0;
    prev = rows;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rows != prev) begin
        ok = 1'b1;
        break;
      end
    end
    check("rows_leave_timeout", 32'(ok), 32'd1);
    check("rows_after_release", 32'(rows), 32'b0001);
    check("held_after_release", 32'(key_held), 32'd0);

    // Bounce on the bottom row: too short to qualify.
    wait_rows(4'b0001, 40, ok);
    check("wait_row0001", 32'(ok), 32'd1);
    press(3, 0, 5, 1'b0, 1'b1);
    wait_rows(4'b1000, 40, ok);
    check("bounce_resume_1000", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    check("bounce_no_valid", 32'(key_valid), 32'd0);

    // '5' with ready low, then '#': '#' is dropped with one overflow pulse.
    ready_fixed = 1'b0;
    exp_q.push_back(keymap[4]);
    press(1, 1, 50, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    exp_ovf++;
    press(3, 2, 50, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    check("ovf_keep_valid", 32'(key_valid), 32'd1);
    check("ovf_keep_code", 32'(key_code), 32'h5);
    ready_fixed = 1'b1;
    repeat (5) @(negedge clk);
    check("drained", 32'(key_valid), 32'd0);

    // Multi-hot columns are ignored while rows keep rotating.
    force_cols = 3'b110;
    force_en = 1'b1;
    chg = 0;
    hcnt = 0;
    prev = rows;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rows != prev) chg++;
      if (key_held) hcnt++;
      prev = rows;
    end
    force_en = 1'b0;
    check("multihot_rotates", 32'(chg >= 9), 32'd1);
    check("multihot_no_held", 32'(hcnt), 32'd0);

    // Random keys with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 2);
      exp_q.push_back(keymap[r * 3 + c]);
      press(r, c, 45, 1'b1, 1'b1);
      repeat (35) @(negedge clk);
    end
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    repeat (10) @(negedge clk);

    // Reset while in RELEASE with a key pending: the key is lost at once.
    ready_fixed = 1'b0;
    press(0, 0, 45, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(key_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(key_valid), 32'd0);
    check("midrst_code", 32'(key_code), 32'hF);
    check("midrst_rows", 32'(rows), 32'b1000);
    check("midrst_held", 32'(key_held), 32'd0);
    key_down = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    release_and_check_scan();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("overflow_count", 32'(ovf_seen), 32'(exp_ovf));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 16: clock cycles each row is driven during scanning (>=3).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles that qualify a press or a release (>=2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port cols, input, 3 bits: keypad column sense, active-high, asynchronous to clk; bit2 is the left column.
REQ-006 The block SHALL have port rows, output, 4 bits: one-hot active-high row drive; bit3 is the top row.
REQ-007 The block SHALL have port key_valid, output, 1 bit: key_code holds a qualified key.
REQ-008 The block SHALL have port key_ready, input, 1 bit: consumer accepts key_code.
REQ-009 The block SHALL have port key_code, output, 4 bits: qualified key code.
REQ-010 The block SHALL have port key_held, output, 1 bit: a qualified key is currently held down.
REQ-011 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a press is dropped.

Function
REQ-012 cols SHALL pass through a 2-flop synchronizer; "cs" below denotes the synchronized value, and all decisions SHALL use cs only.
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-014 SCAN: rows SHALL rotate 1000->0100->0010->0001->1000, each row held SCAN_DIV cycles; cs SHALL be sampled on the last dwell cycle only.
REQ-015 In SCAN, a sample with exactly one cs bit set SHALL capture that pattern, freeze rows and enter DEBOUNCE; a zero or multi-hot sample SHALL be ignored.
REQ-016 DEBOUNCE: a counter SHALL increment each cycle cs equals the captured pattern; on any mismatch the FSM SHALL return to SCAN with rows advanced to the next row.
REQ-017 When the DEBOUNCE counter reaches DEBOUNCE_CYCLES, the FSM SHALL enter PRESSED for one cycle.
REQ-018 Key encoding ({row,col}) SHALL be: top row 1,2,3; second row 4,5,6; third row 7,8,9; bottom row left=4'hA, middle=4'h0, right=4'hB.
REQ-019 PRESSED, key_valid low: on the next cycle key_code SHALL load the encoding and key_valid SHALL go high.
REQ-020 PRESSED, key_valid already high: key_code SHALL be kept, the new key dropped, and overflow SHALL pulse high on the next cycle.
REQ-021 PRESSED SHALL always be followed by RELEASE; key_held SHALL be high exactly in DEBOUNCE-qualified states PRESSED and RELEASE.
REQ-022 RELEASE: rows SHALL stay frozen; a counter SHALL count consecutive cycles with cs==0, resetting on any nonzero cs.
REQ-023 At DEBOUNCE_CYCLES in RELEASE, the FSM SHALL enter SCAN at the next row with the dwell counter cleared.
REQ-024 Handshake: key_valid SHALL stay high and key_code SHALL stay stable until a cycle with key_valid&key_ready; key_valid SHALL clear on the following edge.
REQ-025 If acceptance and a new load coincide in the same cycle, the new key SHALL load and key_valid SHALL stay high with no overflow.
REQ-026 key_ready while key_valid is low SHALL have no effect.
REQ-027 All counters SHALL saturate at their terminal value and never wrap.

Reset
REQ-028 While rst_n is low: FSM=SCAN, rows=4'b1000, dwell and debounce counters=0, synchronizer=0, key_valid=0, key_code=4'hF, key_held=0, overflow=0.
REQ-029 rst_n assertion mid-operation (any state) SHALL apply REQ-028 immediately, and a pending key SHALL be lost.
REQ-030 After rst_n deasserts, scanning SHALL start at row 1000 on the first clk edge.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-031 Idle, cols=000 -> rows cycles 1000,0100,0010,0001 every 4 cycles; key_valid stays 0.
REQ-032 cols=010 held while rows=0010 for 40 cycles, key_ready=1 -> key_code=4'h8, key_valid high exactly 1 cycle, rows frozen at 0010 until release, then 0001.
REQ-033 cols=100 while rows=0001 for 5 cycles only (bounce) -> no key_valid, scan resumes at 1000.
REQ-034 Press '5' (ready=0), release, then press '#' -> key_code stays 4'h5, overflow pulses once, key_held high during each press.
REQ-035 cols=110 on any row -> ignored; rows keep rotating.
REQ-036 rst_n low during RELEASE with key_valid=1 -> key_valid=0, key_code=4'hF, rows=1000 before the next clk edge.
